// File: rtl/word_stream_loader.sv
// word_stream_loader: writes an upstream word stream into instruction memory until a terminator or DEPTH words
module word_stream_loader #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W:0] depth_c = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       sum_q, sum_d;
    logic              full_q, full_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fire;

    // word_count doubles as the write pointer since every written word advances both
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        full_d  = full_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fire    = (state_q == LOAD) && in_valid;
        if (state_q != LOAD && start) begin
            state_d = LOAD;
            cnt_d   = '0;
            sum_d   = '0;
            full_d  = 1'b0;
        end else if (fire && in_word == END_WORD) begin
            state_d = DONE;
        end else if (fire) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = in_word;
            cnt_d   = cnt_q + 1'b1;
            sum_d   = sum_q + in_word;
            if (cnt_d == depth_c) begin
                state_d = DONE;
                full_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            full_q  <= full_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = state_q == LOAD;
    assign busy       = state_q == LOAD;
    assign done       = state_q == DONE;
    assign full       = full_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = cnt_q;
    assign checksum   = sum_q;
endmodule

// File: tb/tb_word_stream_loader.sv
// tb_word_stream_loader: vector table plus corner sequences against a full-size and a DEPTH=4 loader
module tb_word_stream_loader;
    localparam logic [31:0] END_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0, use_b = 1'b0;
    logic [31:0] in_word = '0;

    logic        a_ready, a_we, a_busy, a_done, a_full;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_sum;
    logic [10:0] a_cnt;
    logic        b_ready, b_we, b_busy, b_done, b_full;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata, b_sum;
    logic [2:0]  b_cnt;

    logic        m_ready, m_we, m_busy, m_done, m_full;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_sum;
    logic [10:0] m_cnt;

    logic [41:0] sb[$];
    logic [41:0] mon_e;
    int          exp_ptr = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    word_stream_loader u_a (
        .clk(clk), .rst_n(rst_n), .start(start && !use_b), .in_word(in_word),
        .in_valid(in_valid && !use_b), .in_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .busy(a_busy), .done(a_done), .full(a_full),
        .word_count(a_cnt), .checksum(a_sum)
    );

    word_stream_loader #(.ADDR_W(2), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start && use_b), .in_word(in_word),
        .in_valid(in_valid && use_b), .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .busy(b_busy), .done(b_done), .full(b_full),
        .word_count(b_cnt), .checksum(b_sum)
    );

    assign m_ready = use_b ? b_ready : a_ready;
    assign m_we    = use_b ? b_we : a_we;
    assign m_busy  = use_b ? b_busy : a_busy;
    assign m_done  = use_b ? b_done : a_done;
    assign m_full  = use_b ? b_full : a_full;
    assign m_addr  = use_b ? {8'b0, b_addr} : a_addr;
    assign m_wdata = use_b ? b_wdata : a_wdata;
    assign m_sum   = use_b ? b_sum : a_sum;
    assign m_cnt   = use_b ? {8'b0, b_cnt} : a_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // every write strobe must match the oldest expected write
    always @(posedge clk) begin
        #1;
        if (a_we || b_we) begin
            chk("both_we", {63'b0, a_we && b_we}, 64'd0);
            if (sb.size() == 0) chk("extra_we", {63'b0, m_we}, 64'd0);
            else begin
                mon_e = sb.pop_front();
                chk("write", {22'b0, m_addr, m_wdata}, {22'b0, mon_e});
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, {48'b0, m_ready, m_we, m_busy, m_done, m_full, m_cnt}, 64'd0);
        chk({nm, "_addr_data"}, {22'b0, m_addr, m_wdata}, 64'd0);
        chk({nm, "_sum"}, {32'b0, m_sum}, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] w);
        int k = 0;
        @(negedge clk);
        in_word  = w;
        in_valid = 1'b1;
        while (!m_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!m_ready) begin
            chk("ready_timeout", {63'b0, m_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (w != END_W) begin
            sb.push_back({exp_ptr[9:0], w});
            exp_ptr++;
        end
        @(posedge clk);
    endtask

    task automatic begin_load();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        exp_ptr  = 0;
        @(negedge clk);
        start = 1'b0;
        chk("start_state", {58'b0, m_done, m_busy, m_full, m_ready, 2'b0}, {58'b0, 4'b0101, 2'b0});
        chk("start_cnt", {53'b0, m_cnt}, 64'd0);
        chk("start_sum", {32'b0, m_sum}, 64'd0);
    endtask

    task automatic chk_end(input string nm, input logic [10:0] cnt, input logic [31:0] sum, input logic fl);
        chk({nm, "_flags"}, {60'b0, m_done, m_busy, m_ready, m_full}, {60'b0, 3'b100, fl});
        chk({nm, "_cnt"}, {53'b0, m_cnt}, {53'b0, cnt});
        chk({nm, "_sum"}, {32'b0, m_sum}, {32'b0, sum});
        chk({nm, "_pending"}, 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        string            nm;
        logic [3:0][31:0] w;
        int               n;
        int               gap;
        logic [10:0]      exp_cnt;
        logic [31:0]      exp_sum;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"b2b",   {32'h0, 32'h01095020, 32'h20090003, 32'h20080005}, 3, 0, 11'd3, 32'h411A5028};
        vecs[1] = '{"gap2",  {32'h0, 32'h01095020, 32'h20090003, 32'h20080005}, 3, 2, 11'd3, 32'h411A5028};
        vecs[2] = '{"empty", {32'h0, 32'h0, 32'h0, 32'h0},                      0, 0, 11'd0, 32'h0};
        vecs[3] = '{"wrap",  {32'h0, 32'h0, 32'h00000020, 32'hFFFFFFF0},        2, 1, 11'd2, 32'h00000010};

        #3 rst_n = 1'b0;
        #1 chk_zero("reset_a");
        use_b = 1'b1;
        #1 chk_zero("reset_b");
        use_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // empty load leaves DONE; the following load restarts from DONE at addr 0
        foreach (vecs[i]) begin
            begin_load();
            for (int j = 0; j < vecs[i].n; j++) begin
                send(vecs[i].w[j]);
                idle(vecs[i].gap);
            end
            send(END_W);
            idle(1);
            chk_end(vecs[i].nm, vecs[i].exp_cnt, vecs[i].exp_sum, 1'b0);
        end

        use_b = 1'b1;
        begin_load();
        send(32'h11111111);
        send(32'h22222222);
        send(32'h33333333);
        send(32'h44444444);
        @(negedge clk);
        in_word  = 32'h55555555;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("full_ready", {63'b0, m_ready}, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_end("full", 11'd4, 32'hAAAAAAAA, 1'b1);
        use_b = 1'b0;

        begin_load();
        send(32'hDEADBEEF);
        send(32'h12345678);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1 chk_zero("reset_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_word  = 32'hCAFEF00D;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("idle_ready", {63'b0, m_ready}, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("idle_no_write", 64'(sb.size()), 64'd0);
        begin_load();
        send(32'h0000_0042);
        send(END_W);
        idle(1);
        chk_end("reload", 11'd1, 32'h0000_0042, 1'b0);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
